// File: rtl/dc_ipu_filter_kernel_weights.sv
// Per-lane 4-tap interpolation weights (nearest/linear/Keys/Catmull-Rom); define DC_IPU_KERNEL_WEIGHTS_NORM_EN to renormalise w1 in cubic modes.
// Latency 3 cycles, one transfer per cycle; all stages hold while out_valid && !out_ready, and in_ready drops with them.
module dc_ipu_filter_kernel_weights #(
    parameter int WEIGHT_WIDTH       = 12,
    parameter int WEIGHT_FRACT_WIDTH = 10,
    parameter int LANES              = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_mode,
    input  logic [WEIGHT_WIDTH-1:0]           in_coef,
    input  logic [LANES*WEIGHT_WIDTH-1:0]     in_alpha,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*4*WEIGHT_WIDTH-1:0]   out_weights
);
    localparam int W  = WEIGHT_WIDTH;
    localparam int F  = WEIGHT_FRACT_WIDTH;
    localparam int SW = W + 2;

    typedef logic signed [W-1:0]  wt_t;
    typedef logic signed [SW-1:0] sum_t;
    typedef logic [3:0][SW-1:0]   quad_t;
    typedef logic [3:0][W-1:0]    taps_t;

    localparam wt_t ONE      = wt_t'(2**F);
    localparam wt_t TMAX     = wt_t'(2**F - 1);
    localparam wt_t HALF     = wt_t'(2**(F-1));
    localparam wt_t NEG_HALF = wt_t'(-(2**(F-1)));
    localparam wt_t WMAX     = wt_t'(2**(W-1) - 1);
    localparam wt_t WMIN     = wt_t'(-(2**(W-1)));

`ifdef DC_IPU_KERNEL_WEIGHTS_NORM_EN
    localparam logic NORM_EN = 1'b1;
`else
    localparam logic NORM_EN = 1'b0;
`endif

    function automatic wt_t mul(input wt_t x, input wt_t y);
        logic signed [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        return wt_t'(p >>> F);
    endfunction

    function automatic sum_t ext(input wt_t x);
        return sum_t'(x);
    endfunction

    function automatic wt_t sat(input sum_t x);
        if (x > ext(WMAX)) return WMAX;
        if (x < ext(WMIN)) return WMIN;
        return wt_t'(x);
    endfunction

    function automatic wt_t clamp(input wt_t x);
        if (x[W-1]) return '0;
        if (x > TMAX) return TMAX;
        return x;
    endfunction

    // Cubic terms expanded over the shared products t^2, t^3, a*t, a*t^2, a*t^3.
    function automatic quad_t kernel(input logic [1:0] mode, input wt_t a, input wt_t t, input wt_t t2);
        wt_t   t3;
        sum_t  et, et2, et3, eat, eat2, eat3, one;
        quad_t q;
        t3   = mul(t2, t);
        et   = ext(t);
        et2  = ext(t2);
        et3  = ext(t3);
        eat  = ext(mul(a, t));
        eat2 = ext(mul(a, t2));
        eat3 = ext(mul(a, t3));
        one  = ext(ONE);
        q    = '0;
        case (mode)
            2'd0: begin
                if (t < HALF) q[1] = one;
                else          q[2] = one;
            end
            2'd1: begin
                q[1] = one - et;
                q[2] = et;
            end
            default: begin
                q[0] = eat3 - eat2 - eat2 + eat;
                q[1] = eat3 + et3 + et3 - eat2 - et2 - et2 - et2 + one;
                q[2] = eat2 + eat2 + et2 + et2 + et2 - eat3 - et3 - et3 - eat;
                q[3] = eat2 - eat3;
            end
        endcase
        return q;
    endfunction

    function automatic taps_t saturate_taps(input quad_t q, input logic renorm);
        taps_t r;
        sum_t  rest;
        for (int k = 0; k < 4; k++) r[k] = sat($signed(q[k]));
        rest = ext($signed(r[0])) + ext($signed(r[2])) + ext($signed(r[3]));
        if (renorm) r[1] = sat(ext(ONE) - rest);
        return r;
    endfunction

    logic                    adv;
    logic                    v0, v1, v2;
    logic [1:0]              s0_mode;
    wt_t                     s0_a;
    logic [LANES-1:0][W-1:0] s0_t, s0_t2;
    logic                    s1_cubic;
    quad_t [LANES-1:0]       s1_w;
    taps_t [LANES-1:0]       s2_w;

    wt_t                     in_a;
    logic [LANES-1:0][W-1:0] in_t, in_t2;
    quad_t [LANES-1:0]       s1_nxt;
    taps_t [LANES-1:0]       s2_nxt;

    assign adv         = !v2 || out_ready;
    assign in_ready    = adv;
    assign out_valid   = v2;
    assign out_weights = s2_w;

    always_comb begin
        in_t   = '0;
        in_t2  = '0;
        s1_nxt = '0;
        s2_nxt = '0;
        in_a   = (in_mode == 2'd3) ? NEG_HALF : wt_t'(in_coef);
        for (int l = 0; l < LANES; l++) begin
            in_t[l]   = clamp(wt_t'(in_alpha[l*W +: W]));
            in_t2[l]  = mul(in_t[l], in_t[l]);
            s1_nxt[l] = kernel(s0_mode, s0_a, s0_t[l], s0_t2[l]);
            s2_nxt[l] = saturate_taps(s1_w[l], s1_cubic && NORM_EN);
        end
    end

    // Data registers load only behind a valid bit so outputs stay put across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            s0_mode  <= '0;
            s0_a     <= '0;
            s0_t     <= '0;
            s0_t2    <= '0;
            s1_cubic <= 1'b0;
            s1_w     <= '0;
            s2_w     <= '0;
        end else if (adv) begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
            if (in_valid) begin
                s0_mode <= in_mode;
                s0_a    <= in_a;
                s0_t    <= in_t;
                s0_t2   <= in_t2;
            end
            if (v0) begin
                s1_cubic <= s0_mode[1];
                s1_w     <= s1_nxt;
            end
            if (v1) s2_w <= s2_nxt;
        end
    end
endmodule
